dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-ported data memory between the two load/store lanes of the dual-issue core.
//  Grants at most one access per cycle; lane 0 wins a tie unless lane 1 lost the previous cycle.
//  Generates byte enables and steers store data for byte, half and word accesses.
//  Returns load data one cycle after the grant (extracted, sign/zero-extended); rejects misaligned accesses.
//  Sits between the two LSU lanes and data_memory (registered read, byte-wise write enables).
// PARAMETERS
//  ADDR_W  32  request/memory address width
//  CNT_W   32  width of the conflict-stall counter (saturating)
// PORTS
//  clk           in   1        core clock; all state on rising edge
//  rst           in   1        reset; synchronous, active-high
//  req_valid     in   [1:0]    per-lane access request
//  req_ready     out  [1:0]    per-lane grant (combinational; accepted when valid&ready)
//  req_addr      in   [1:0][ADDR_W-1:0]  byte address
//  req_wdata     in   [1:0][31:0]        store data, right-aligned (bits [7:0]/[15:0]/[31:0])
//  req_write     in   [1:0]    1=store, 0=load
//  req_size      in   [1:0][1:0]  0=byte 1=half 2=word 3=illegal
//  req_unsigned  in   [1:0]    load zero-extend (LBU/LHU) when 1
//  rsp_valid     out  [1:0]    one-cycle response pulse for the lane granted last cycle
//  rsp_rdata     out  32       load result (0 for stores/errors); shared by both lanes
//  rsp_err       out  1        misaligned or illegal-size access; qualifies rsp_valid
//  mem_addr      out  ADDR_W   to data memory; word address bits [13:2] used downstream
//  mem_wdata     out  32       lane-steered store data
//  mem_we        out  4        byte write enables
//  mem_re        out  1        read enable
//  mem_rdata     in   32       registered memory read data, valid the cycle after mem_re
//  conflict_cnt  out  CNT_W    cycles in which both lanes requested (one stalled)
// BEHAVIOUR
//  Reset: prio=0, inflight cleared; rsp_valid=0, rsp_err=0, rsp_rdata=0, conflict_cnt=0.
//   mem_we=0 and mem_re=0 whenever rst=1.
//  Arbitration, combinational:
//   - One lane valid: that lane is granted.
//   - Both valid: lane prio is granted and the other sees req_ready=0.
//   - No lane is granted while rst=1.
//  prio update on each edge:
//   - conflict: prio <= loser, conflict_cnt += 1 (saturates at all-ones);
//   - otherwise prio <= 0.
//   - Both lanes are therefore served in consecutive cycles; neither starves.
//  Alignment check: half needs addr[0]=0; word needs addr[1:0]=0; size 3 is always an error.
//   - A misaligned granted access drives mem_we=0, mem_re=0. It is still granted.
//  Aligned store: mem_wdata = wdata replicated into lanes.
//   - byte: {4{b}}; half: {2{h}}; word: w.
//   - mem_we: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'hF. mem_re=0.
//  Aligned load: mem_re=1, mem_we=0.
//  Idle cycle: mem_addr/mem_wdata hold the granted lane's values, else 0; enables 0.
//  Inflight register, captured at the grant: {valid, lane, write, size, off=addr[1:0], unsigned, err}.
//  Cycle after the grant:
//   - rsp_valid[lane]=1 for exactly one cycle.
//   - rsp_err = inflight err.
//   - load: rsp_rdata = mem_rdata >> (8*off), truncated to size, sign/zero-extended.
//   - store or error: rsp_rdata=0.
//  Fixed one-cycle latency; there is no response backpressure.
//  Back-to-back grants are supported; the inflight register is rewritten every cycle.
//  Read-after-write to the same word in consecutive cycles returns the new data (the memory write precedes the read).
//  Reset mid-operation: the inflight access is dropped; no rsp_valid in the cycle after rst.
//  Address ordering hazards between lanes are the pipeline's responsibility; older-lane-first holds only via prio.
// STRUCTURE
//  Package dmem_arb_pkg:
//   - mem_size_e {SZ_B, SZ_H, SZ_W, SZ_BAD};
//   - inflight_t struct;
//   - lane index constants LANE0/LANE1.
//  Sub-module lsu_align (combinational): store steering + byte enables + misalign detect,
//   and load extraction/extension. Instantiated once for the request path; its extract function is shared.
//  Top module holds the arbiter, prio flop, inflight register and conflict counter.
// TESTING
//  1. Lane0 SW addr 0x100 data 0xDEADBEEF, then lane0 LW 0x100:
//     mem_we=4'hF; rsp_valid[0] next cycle; load rsp_rdata=0xDEADBEEF.
//  2. Both lanes LW same cycle (0x10, 0x20):
//     cycle0 grant lane0; cycle1 grant lane1 (prio=1); conflict_cnt=1; responses on rsp_valid[0] then [1].
//  3. Mem word 0x80FF7F01, LB/LBU at offsets 0..3:
//     0x01, 0x7F, 0xFFFFFFFF (LBU 0xFF), 0xFFFFFF80 (LBU 0x80); LH off 2 = 0xFFFF80FF.
//  4. SB 0xAB to addr 0x103:
//     mem_we=4'b1000, mem_wdata=0xABABABAB; LW returns 0xAB in [31:24] with other bytes unchanged.
//  5. LH addr 0x101 and SW addr 0x102:
//     granted, mem_re=mem_we=0, rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
//  6. rst asserted in the cycle after a LW grant:
//     no rsp_valid, conflict_cnt=0, prio=0; traffic after rst behaves as after power-up.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types, lane constants and load extraction for the dmem arbiter
package dmem_arb_pkg;

  // Access size encoding as carried on req_size.
  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } mem_size_e;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // Everything the response cycle needs about the access granted last cycle.
  typedef struct packed {
    logic      valid;
    logic      lane;
    logic      write;
    mem_size_e size;
    logic [1:0] off;
    logic      uns;
    logic      err;
  } inflight_t;

  // Pull the addressed byte/half/word out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input mem_size_e   size,
                                               input logic        uns);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      SZ_B:    load_extract = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    load_extract = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SZ_W:    load_extract = sh;
      default: load_extract = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - LSU lane and data memory signals of the dmem arbiter
// master: LSU lanes + memory model (drives requests and mem_rdata)
// slave : arbiter (drives grants, responses and memory commands)
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][31:0]       req_wdata;
  logic [1:0]             req_write;
  logic [1:0][1:0]        req_size;
  logic [1:0]             req_unsigned;
  logic [1:0]             rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;
  logic [ADDR_W-1:0]      mem_addr;
  logic [31:0]            mem_wdata;
  logic [3:0]             mem_we;
  logic                   mem_re;
  logic [31:0]            mem_rdata;

  modport master (
    output req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store steering, byte enables, misalign detect and load extraction
// Ports: i_off/i_size/i_wdata -> o_wdata/o_be/o_misalign (request path)
//        i_ld_rdata/i_ld_off/i_ld_size/i_ld_uns -> o_ld_data (response path)
module lsu_align
  import dmem_arb_pkg::*;
(
  input  logic [1:0]  i_off,
  input  mem_size_e   i_size,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_misalign,
  input  logic [31:0] i_ld_rdata,
  input  logic [1:0]  i_ld_off,
  input  mem_size_e   i_ld_size,
  input  logic        i_ld_uns,
  output logic [31:0] o_ld_data
);

  always_comb begin
    o_wdata    = 32'd0;
    o_be       = 4'd0;
    o_misalign = 1'b0;
    case (i_size)
      SZ_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_be    = 4'b0001 << i_off;
      end
      SZ_H: begin
        o_wdata    = {2{i_wdata[15:0]}};
        o_be       = 4'b0011 << i_off;
        o_misalign = i_off[0];
      end
      SZ_W: begin
        o_wdata    = i_wdata;
        o_be       = 4'hF;
        o_misalign = (i_off != 2'd0);
      end
      default: o_misalign = 1'b1;
    endcase
  end

  assign o_ld_data = load_extract(i_ld_rdata, i_ld_off, i_ld_size, i_ld_uns);

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-lane arbiter in front of the single-ported data memory
// Ports: clk, rst (sync, active-high); bus (slave modport: lane requests/responses and
//        memory commands); conflict_cnt (saturating count of two-lane request cycles)
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  dmem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic             r_prio;
  inflight_t        r_inf;
  logic [CNT_W-1:0] r_cnt;

  logic        w_both;
  logic        w_any;
  logic        w_lane;
  mem_size_e   w_size;
  logic        w_write;
  logic [1:0]  w_off;
  logic [31:0] w_st_data;
  logic [3:0]  w_be;
  logic        w_mis;
  logic [31:0] w_ld_data;
  logic        w_rsp;

  // A tie goes to r_prio, which names last cycle's loser (or lane 0).
  assign w_both  = bus.req_valid[0] & bus.req_valid[1];
  assign w_any   = (|bus.req_valid) & ~rst;
  assign w_lane  = w_both ? r_prio : bus.req_valid[1];
  assign w_size  = mem_size_e'(bus.req_size[w_lane]);
  assign w_write = bus.req_write[w_lane];
  assign w_off   = bus.req_addr[w_lane][1:0];

  lsu_align u_align (
    .i_off      (w_off),
    .i_size     (w_size),
    .i_wdata    (bus.req_wdata[w_lane]),
    .o_wdata    (w_st_data),
    .o_be       (w_be),
    .o_misalign (w_mis),
    .i_ld_rdata (bus.mem_rdata),
    .i_ld_off   (r_inf.off),
    .i_ld_size  (r_inf.size),
    .i_ld_uns   (r_inf.uns),
    .o_ld_data  (w_ld_data)
  );

  assign bus.req_ready = w_any ? (w_lane ? 2'b10 : 2'b01) : 2'b00;
  assign bus.mem_addr  = w_any ? bus.req_addr[w_lane] : '0;
  assign bus.mem_wdata = w_any ? w_st_data : 32'd0;
  // Misaligned accesses are still granted but never touch memory.
  assign bus.mem_we    = (w_any & w_write & ~w_mis) ? w_be : 4'd0;
  assign bus.mem_re    = w_any & ~w_write & ~w_mis;

  // Response gated by rst so an access granted just before reset is dropped at once.
  assign w_rsp         = r_inf.valid & ~rst;
  assign bus.rsp_valid = w_rsp ? (r_inf.lane ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_err   = w_rsp & r_inf.err;
  assign bus.rsp_rdata = (w_rsp & ~r_inf.write & ~r_inf.err) ? w_ld_data : 32'd0;

  assign conflict_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= LANE0;
      r_inf  <= '0;
      r_cnt  <= '0;
    end else begin
      r_inf <= '{valid: w_any, lane: w_lane, write: w_write, size: w_size,
                 off: w_off, uns: bus.req_unsigned[w_lane], err: w_mis};
      if (w_both) begin
        r_prio <= ~w_lane;
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_prio <= LANE0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  localparam int NOP = 0, SW = 1, SH = 2, SB = 3, LW = 4, LH = 5, LB = 6, LHU = 7, LBU = 8, LX = 9;

  typedef struct {
    logic        v;
    logic        wr;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] a;
    logic [31:0] d;
  } lreq_t;

  typedef struct {
    lreq_t       l0;
    lreq_t       l1;
    logic [1:0]  rdy;
    logic [3:0]  we;
    logic        re;
    logic [31:0] wd;
    logic [1:0]  rv;
    logic        err;
    logic [31:0] rd;
    logic [31:0] cnt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] conflict_cnt;
  logic [31:0] mem [0:4095];
  vec_t        vecs[$];
  int          total;
  int          bad;

  dmem_port_arbiter_if #(.ADDR_W(32)) bus ();

  dmem_port_arbiter #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: byte-wise writes, registered read.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.mem_we[b]) mem[bus.mem_addr[13:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[13:2]];
  end

  function automatic lreq_t op(input int code, input logic [31:0] a, input logic [31:0] d);
    lreq_t r;
    r = '{v: 1'b1, wr: 1'b0, sz: 2'd2, un: 1'b0, a: a, d: d};
    case (code)
      SW:  begin r.wr = 1'b1; r.sz = 2'd2; end
      SH:  begin r.wr = 1'b1; r.sz = 2'd1; end
      SB:  begin r.wr = 1'b1; r.sz = 2'd0; end
      LW:  r.sz = 2'd2;
      LH:  r.sz = 2'd1;
      LB:  r.sz = 2'd0;
      LHU: begin r.sz = 2'd1; r.un = 1'b1; end
      LBU: begin r.sz = 2'd0; r.un = 1'b1; end
      LX:  r.sz = 2'd3;
      default: r = '{v: 1'b0, wr: 1'b0, sz: 2'd0, un: 1'b0, a: 32'd0, d: 32'd0};
    endcase
    return r;
  endfunction

  task automatic add(input lreq_t a, input lreq_t b, input logic [1:0] rdy, input logic [3:0] we,
                     input logic re, input logic [31:0] wd, input logic [1:0] rv, input logic err,
                     input logic [31:0] rd, input logic [31:0] cnt);
    vec_t v;
    v.l0 = a; v.l1 = b; v.rdy = rdy; v.we = we; v.re = re; v.wd = wd;
    v.rv = rv; v.err = err; v.rd = rd; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic apply(input lreq_t a, input lreq_t b);
    bus.req_valid    = {b.v, a.v};
    bus.req_write    = {b.wr, a.wr};
    bus.req_size     = {b.sz, a.sz};
    bus.req_unsigned = {b.un, a.un};
    bus.req_addr     = {b.a, a.a};
    bus.req_wdata    = {b.d, a.d};
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] rdy, input logic [3:0] we, input logic re,
                         input logic [31:0] wd, input logic [1:0] rv, input logic err,
                         input logic [31:0] rd, input logic [31:0] cnt);
    chk({tag, ".ready"}, {30'd0, bus.req_ready}, {30'd0, rdy});
    chk({tag, ".mem_we"}, {28'd0, bus.mem_we}, {28'd0, we});
    chk({tag, ".mem_re"}, {31'd0, bus.mem_re}, {31'd0, re});
    chk({tag, ".mem_wdata"}, bus.mem_wdata, wd);
    chk({tag, ".rsp_valid"}, {30'd0, bus.rsp_valid}, {30'd0, rv});
    chk({tag, ".rsp_err"}, {31'd0, bus.rsp_err}, {31'd0, err});
    chk({tag, ".rsp_rdata"}, bus.rsp_rdata, rd);
    chk({tag, ".conflict_cnt"}, conflict_cnt, cnt);
  endtask

  task automatic step(input string tag, input lreq_t a, input lreq_t b, input logic [1:0] rdy,
                      input logic [3:0] we, input logic re, input logic [31:0] wd, input logic [1:0] rv,
                      input logic err, input logic [31:0] rd, input logic [31:0] cnt);
    @(posedge clk); #1;
    apply(a, b);
    @(negedge clk);
    chk_all(tag, rdy, we, re, wd, rv, err, rd, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    lreq_t idle;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    idle = op(NOP, 32'd0, 32'd0);

    // SW/LW round trip, read-after-write in consecutive cycles
    add(idle, idle, 2'b00, 4'h0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 0);
    add(op(SW, 32'h100, 32'hDEADBEEF), idle, 2'b01, 4'hF, 1'b0, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0, 0);
    add(op(LW, 32'h100, 32'h0), idle, 2'b01, 4'h0, 1'b1, 32'h0, 2'b01, 1'b0, 32'h0, 0);
    add(idle, idle, 2'b00, 4'h0, 1'b0, 32'h0, 2'b01, 1'b0, 32'hDEADBEEF, 0);
    // two-lane conflict
    add(op(SW, 32'h10, 32'h11111111), idle, 2'b01, 4'hF, 1'b0, 32'h11111111, 2'b00, 1'b0, 32'h0, 0);
    add(idle, op(SW, 32'h20, 32'h22222222), 2'b10, 4'hF, 1'b0, 32'h22222222, 2'b01, 1'b0, 32'h0, 0);
    add(op(LW, 32'h10, 32'h0), op(LW, 32'h20, 32'h0), 2'b01, 4'h0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h0, 0);
    add(idle, op(LW, 32'h20, 32'h0), 2'b10, 4'h0, 1'b1, 32'h0, 2'b01, 1'b0, 32'h11111111, 1);
    add(idle, idle, 2'b00, 4'h0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h22222222, 1);
    // byte/half extraction of 0x80FF7F01
    add(op(SW, 32'h200, 32'h80FF7F01), idle, 2'b01, 4'hF, 1'b0, 32'h80FF7F01, 2'b00, 1'b0, 32'h0, 1);
    add(op(LB, 32'h200, 32'h0), idle, 2'b01, 4'h0, 1'b1, 32'h0, 2'b01, 1'b0, 32'h0, 1);
    add(op(LB, 32'h201, 32'h0), idle, 2'b01, 4'h0, 1'b1, 32'h0, 2'b01, 1'b0, 32'h00000001, 1);
    add(op(LB, 32'h202, 32'h0), idle, 2'b01, 4'h0, 1'b1, 32'h0, 2'b01, 1'b0, 32'h0000007F, 1);
    add(op(LB, 32'h203, 32'h0), idle, 2'b01, 4'h0, 1'b1, 32'h0, 2'b01, 1'b0, 32'hFFFFFFFF, 1);
    add(op(LBU, 32'h202, 32'h0), idle, 2'b01, 4'h0, 1'b1, 32'h0, 2'b01, 1'b0, 32'hFFFFFF80, 1);
    add(op(LBU, 32'h203, 32'h0), idle, 2'b01, 4'h0, 1'b1, 32'h0, 2'b01, 1'b0, 32'h000000FF, 1);
    add(op(LH, 32'h202, 32'h0), idle, 2'b01, 4'h0, 1'b1, 32'h0, 2'b01, 1'b0, 32'h00000080, 1);
    add(idle, idle, 2'b00, 4'h0, 1'b0, 32'h0, 2'b01, 1'b0, 32'hFFFF80FF, 1);
    // SB to top byte, SH to upper half
    add(op(SB, 32'h103, 32'h000000AB), idle, 2'b01, 4'b1000, 1'b0, 32'hABABABAB, 2'b00, 1'b0, 32'h0, 1);
    add(op(LW, 32'h100, 32'h0), idle, 2'b01, 4'h0, 1'b1, 32'h0, 2'b01, 1'b0, 32'h0, 1);
    add(idle, idle, 2'b00, 4'h0, 1'b0, 32'h0, 2'b01, 1'b0, 32'hABADBEEF, 1);
    // misaligned and illegal-size accesses
    add(op(LH, 32'h101, 32'h0), idle, 2'b01, 4'h0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1);
    add(op(SW, 32'h102, 32'h12345678), idle, 2'b01, 4'h0, 1'b0, 32'h12345678, 2'b01, 1'b1, 32'h0, 1);
    add(idle, idle, 2'b00, 4'h0, 1'b0, 32'h0, 2'b01, 1'b1, 32'h0, 1);
    add(op(SH, 32'h102, 32'h00001234), idle, 2'b01, 4'b1100, 1'b0, 32'h12341234, 2'b00, 1'b0, 32'h0, 1);
    add(op(LW, 32'h100, 32'h0), idle, 2'b01, 4'h0, 1'b1, 32'h0, 2'b01, 1'b0, 32'h0, 1);
    add(idle, idle, 2'b00, 4'h0, 1'b0, 32'h0, 2'b01, 1'b0, 32'h1234BEEF, 1);
    add(idle, op(LX, 32'h100, 32'h0), 2'b10, 4'h0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1);
    add(idle, idle, 2'b00, 4'h0, 1'b0, 32'h0, 2'b10, 1'b1, 32'h0, 1);

    // Power-up reset with a store pending: nothing granted, nothing written.
    rst = 1'b1;
    apply(op(SW, 32'h100, 32'h55555555), idle);
    bus.mem_rdata = 32'd0;
    @(posedge clk);
    @(negedge clk);
    chk_all("reset", 2'b00, 4'h0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply(idle, idle);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tag, vecs[i].l0, vecs[i].l1, vecs[i].rdy, vecs[i].we, vecs[i].re, vecs[i].wd,
           vecs[i].rv, vecs[i].err, vecs[i].rd, vecs[i].cnt);
    end

    // Sustained two-lane contention alternates the grant.
    step("alt0", op(LW, 32'h10, 0), op(LW, 32'h20, 0), 2'b01, 4'h0, 1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1);
    step("alt1", op(LW, 32'h10, 0), op(LW, 32'h20, 0), 2'b10, 4'h0, 1'b1, 32'h0, 2'b01, 1'b0, 32'h11111111, 2);
    step("alt2", op(LW, 32'h10, 0), op(LW, 32'h20, 0), 2'b01, 4'h0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h22222222, 3);
    step("alt3", idle, idle, 2'b00, 4'h0, 1'b0, 32'h0, 2'b01, 1'b0, 32'h11111111, 4);

    // Reset the cycle after a conflicting LW grant.
    step("rst0", op(LW, 32'h200, 0), op(LW, 32'h10, 0), 2'b01, 4'h0, 1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_all("rst1", 2'b00, 4'h0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 5);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all("rst2", 2'b01, 4'h0, 1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 0);
    step("rst3", idle, idle, 2'b00, 4'h0, 1'b0, 32'h0, 2'b01, 1'b0, 32'h80FF7F01, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
